// File: rtl/midi_pkg.sv
// Shared types and helpers for the MIDI preset engine: slot message layout and flash word packing.
// Purely combinational helpers; no latency, no flow control.
package midi_pkg;

    localparam logic [7:0] CC_MSG = 8'hB0;
    localparam logic [7:0] PC_MSG = 8'hC0;

    typedef enum logic [1:0] {
        LOAD,
        IDLE,
        SAVE
    } fl_state_t;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] data1;
        logic [7:0] data2;
        logic [1:0] len;
    } midi_msg_t;

    function automatic logic [31:0] msg_to_word(input midi_msg_t m);
        return {m.status, m.data1, m.data2, 6'b0, m.len};
    endfunction

    function automatic midi_msg_t word_to_msg(input logic [31:0] w);
        midi_msg_t m;
        m.status = w[31:24];
        m.data1  = w[23:16];
        m.data2  = w[15:8];
        m.len    = w[1:0];
        return m;
    endfunction

    // Erased flash reads as all-ones; a zero length marks an empty slot.
    function automatic logic word_ok(input logic [31:0] w);
        return (w[1:0] != 2'd0) && (w != 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/midi_preset_flash_seq.sv
// Flash sequencer: loads every slot after reset, writes them all back on save request.
// One word in flight; strobe holds until ack/rty, drops one cycle between attempts.
module midi_preset_flash_seq
    import midi_pkg::*;
#(
    parameter int unsigned BUTTONS_CNT = 4,
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int unsigned MAX_RTY     = 3,
    localparam int unsigned IW         = (BUTTONS_CNT > 1) ? $clog2(BUTTONS_CNT) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            save_req_i,
    output logic [IW-1:0]   slot_o,
    output logic            rd_valid_o,
    output midi_msg_t       rd_msg_o,
    input  midi_msg_t       wr_msg_i,
    output logic            save_start_o,
    output logic            loaded_o,
    output logic            fl_err_o,
    output logic [23:0]     fl_adr_o,
    output logic [31:0]     fl_dat_o,
    output logic            fl_we_o,
    output logic            fl_stb_o,
    input  logic [31:0]     fl_dat_i,
    input  logic            fl_ack_i,
    input  logic            fl_rty_i
);

    fl_state_t      state_q, state_d;
    logic [IW-1:0]  slot_q, slot_d;
    logic [2:0]     rty_q, rty_d;
    logic           stb_q, stb_d;
    logic [31:0]    dat_q, dat_d;
    logic           loaded_q, loaded_d;
    logic           err_q, err_d;
    logic           advance;
    logic [2:0]     rty_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD;
            slot_q   <= '0;
            rty_q    <= '0;
            stb_q    <= 1'b0;
            dat_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            rty_q    <= rty_d;
            stb_q    <= stb_d;
            dat_q    <= dat_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        rty_d        = rty_q;
        stb_d        = stb_q;
        dat_d        = dat_q;
        loaded_d     = loaded_q;
        err_d        = err_q;
        rd_valid_o   = 1'b0;
        save_start_o = 1'b0;
        advance      = 1'b0;
        rty_nxt      = rty_q + 3'd1;
        case (state_q)
            IDLE: begin
                if (save_req_i) begin
                    state_d      = SAVE;
                    slot_d       = '0;
                    rty_d        = '0;
                    save_start_o = 1'b1;
                end
            end
            default: begin
                // Write data is captured when the strobe rises so learn writes cannot disturb a pending transfer.
                if (!stb_q) begin
                    stb_d = 1'b1;
                    dat_d = (state_q == SAVE) ? msg_to_word(wr_msg_i) : '0;
                end else if (fl_ack_i) begin
                    stb_d      = 1'b0;
                    rd_valid_o = (state_q == LOAD) && word_ok(fl_dat_i);
                    advance    = 1'b1;
                end else if (fl_rty_i) begin
                    stb_d = 1'b0;
                    if (rty_nxt >= 3'(MAX_RTY)) begin
                        err_d   = 1'b1;
                        advance = 1'b1;
                    end else begin
                        rty_d = rty_nxt;
                    end
                end
                if (advance) begin
                    rty_d = '0;
                    if (slot_q == IW'(BUTTONS_CNT - 1)) begin
                        state_d = IDLE;
                        if (state_q == LOAD) loaded_d = 1'b1;
                    end else begin
                        slot_d = slot_q + IW'(1);
                    end
                end
            end
        endcase
    end

    assign slot_o   = slot_q;
    assign rd_msg_o = word_to_msg(fl_dat_i);
    assign loaded_o = loaded_q;
    assign fl_err_o = err_q;
    assign fl_adr_o = BASE_ADDR + 24'({slot_q, 2'b00});
    assign fl_dat_o = dat_q;
    assign fl_we_o  = (state_q == SAVE);
    assign fl_stb_o = stb_q;

endmodule

// File: rtl/midi_preset_engine.sv
// Preset engine: slot RAM, learn capture and press-to-transmit with a 1-deep pending slot.
// Press to tx_trigger is one cycle when idle; tx_busy holds the newest press until released.
module midi_preset_engine
    import midi_pkg::*;
#(
    parameter int unsigned BUTTONS_CNT = 4,
    parameter int unsigned CHANNEL     = 0,
    parameter int unsigned FIRST_CC    = 46,
    parameter int unsigned CC_VALUE    = 127,
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int unsigned MAX_RTY     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUTTONS_CNT-1:0] btn_press,
    input  logic                   learn,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_status,
    input  logic [7:0]             rx_data1,
    input  logic [7:0]             rx_data2,
    input  logic [1:0]             rx_len,
    input  logic                   save_req,
    input  logic                   tx_busy,
    output logic                   tx_trigger,
    output logic [7:0]             tx_status,
    output logic [7:0]             tx_data1,
    output logic [7:0]             tx_data2,
    output logic [7:0]             tx_bits,
    output logic [23:0]            fl_adr,
    output logic [31:0]            fl_dat_o,
    output logic                   fl_we,
    output logic                   fl_stb,
    input  logic [31:0]            fl_dat_i,
    input  logic                   fl_ack,
    input  logic                   fl_rty,
    output logic                   loaded,
    output logic                   dirty,
    output logic                   learn_ok,
    output logic                   fl_err
);

    localparam int unsigned IW = (BUTTONS_CNT > 1) ? $clog2(BUTTONS_CNT) : 1;

    midi_msg_t              ram_q [BUTTONS_CNT];
    logic [BUTTONS_CNT-1:0] valid_q;
    logic                   pend_vld_q, arm_vld_q, dirty_q, learn_ok_q, tx_trig_q;
    logic [IW-1:0]          pend_idx_q, arm_idx_q;
    logic [7:0]             tx_status_q, tx_data1_q, tx_data2_q, tx_bits_q;

    logic [IW-1:0]          fl_slot, sel_idx, eff_idx;
    logic                   rd_valid, save_start, press_any, press_tx, eff_vld, learn_wr;
    midi_msg_t              rd_msg, wr_msg, eff_msg, rx_msg;

    midi_preset_flash_seq #(
        .BUTTONS_CNT (BUTTONS_CNT),
        .BASE_ADDR   (BASE_ADDR),
        .MAX_RTY     (MAX_RTY)
    ) u_flash_seq (
        .clk          (clk),
        .rst          (rst),
        .save_req_i   (save_req),
        .slot_o       (fl_slot),
        .rd_valid_o   (rd_valid),
        .rd_msg_o     (rd_msg),
        .wr_msg_i     (wr_msg),
        .save_start_o (save_start),
        .loaded_o     (loaded),
        .fl_err_o     (fl_err),
        .fl_adr_o     (fl_adr),
        .fl_dat_o     (fl_dat_o),
        .fl_we_o      (fl_we),
        .fl_stb_o     (fl_stb),
        .fl_dat_i     (fl_dat_i),
        .fl_ack_i     (fl_ack),
        .fl_rty_i     (fl_rty)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = int'(BUTTONS_CNT) - 1; i >= 0; i--) begin
            if (btn_press[i]) sel_idx = IW'(i);
        end
        press_any = |btn_press;
        press_tx  = press_any && !learn;
        // A fresh press bypasses the pending register to reach the wire in one cycle.
        eff_vld   = press_tx || pend_vld_q;
        eff_idx   = press_tx ? sel_idx : pend_idx_q;
        if (valid_q[eff_idx]) begin
            eff_msg = ram_q[eff_idx];
        end else begin
            eff_msg.status = CC_MSG | {4'h0, 4'(CHANNEL)};
            eff_msg.data1  = 8'(FIRST_CC) + 8'(eff_idx);
            eff_msg.data2  = 8'(CC_VALUE);
            eff_msg.len    = 2'd3;
        end
        wr_msg   = valid_q[fl_slot] ? ram_q[fl_slot] : '0;
        rx_msg   = {rx_status, rx_data1, rx_data2, rx_len};
        learn_wr = rx_valid && (rx_len != 2'd0) && learn && arm_vld_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BUTTONS_CNT); i++) ram_q[i] <= '0;
            valid_q     <= '0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            arm_vld_q   <= 1'b0;
            arm_idx_q   <= '0;
            dirty_q     <= 1'b0;
            learn_ok_q  <= 1'b0;
            tx_trig_q   <= 1'b0;
            tx_status_q <= '0;
            tx_data1_q  <= '0;
            tx_data2_q  <= '0;
            tx_bits_q   <= '0;
        end else begin
            tx_trig_q  <= 1'b0;
            learn_ok_q <= 1'b0;
            if (rd_valid) begin
                ram_q[fl_slot]   <= rd_msg;
                valid_q[fl_slot] <= 1'b1;
            end
            if (save_start) dirty_q <= 1'b0;
            // Placed after the flash load so a learn write to the same slot wins.
            if (learn_wr) begin
                ram_q[arm_idx_q]   <= rx_msg;
                valid_q[arm_idx_q] <= 1'b1;
                dirty_q            <= 1'b1;
                learn_ok_q         <= 1'b1;
                arm_vld_q          <= 1'b0;
            end
            if (!learn) arm_vld_q <= 1'b0;
            if (press_any && learn) begin
                arm_vld_q <= 1'b1;
                arm_idx_q <= sel_idx;
            end
            if (eff_vld && !tx_busy) begin
                tx_trig_q   <= 1'b1;
                tx_status_q <= eff_msg.status;
                tx_data1_q  <= eff_msg.data1;
                tx_data2_q  <= eff_msg.data2;
                tx_bits_q   <= 8'(eff_msg.len) * 8'd10;
                pend_vld_q  <= 1'b0;
            end else begin
                pend_vld_q <= eff_vld;
                pend_idx_q <= eff_idx;
            end
        end
    end

    assign tx_trigger = tx_trig_q;
    assign tx_status  = tx_status_q;
    assign tx_data1   = tx_data1_q;
    assign tx_data2   = tx_data2_q;
    assign tx_bits    = tx_bits_q;
    assign dirty      = dirty_q;
    assign learn_ok   = learn_ok_q;

endmodule

// File: tb/tb_midi_preset_engine.sv
// Bench for midi_preset_engine: flash responder model, table-driven press vectors, corner sequences, random reference-model run.
module tb_midi_preset_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn_press;
    logic        learn, rx_valid, save_req, tx_busy;
    logic [7:0]  rx_status, rx_data1, rx_data2;
    logic [1:0]  rx_len;
    logic        tx_trigger;
    logic [7:0]  tx_status, tx_data1, tx_data2, tx_bits;
    logic [23:0] fl_adr;
    logic [31:0] fl_dat_o, fl_dat_i;
    logic        fl_we, fl_stb, fl_ack, fl_rty;
    logic        loaded, dirty, learn_ok, fl_err;

    always #5 clk = ~clk;

    midi_preset_engine dut (
        .clk(clk), .rst(rst), .btn_press(btn_press), .learn(learn),
        .rx_valid(rx_valid), .rx_status(rx_status), .rx_data1(rx_data1),
        .rx_data2(rx_data2), .rx_len(rx_len), .save_req(save_req), .tx_busy(tx_busy),
        .tx_trigger(tx_trigger), .tx_status(tx_status), .tx_data1(tx_data1),
        .tx_data2(tx_data2), .tx_bits(tx_bits), .fl_adr(fl_adr), .fl_dat_o(fl_dat_o),
        .fl_we(fl_we), .fl_stb(fl_stb), .fl_dat_i(fl_dat_i), .fl_ack(fl_ack),
        .fl_rty(fl_rty), .loaded(loaded), .dirty(dirty), .learn_ok(learn_ok), .fl_err(fl_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- flash responder ----------------
    typedef struct {
        logic [23:0] adr;
        logic        we;
        logic [31:0] dat;
        bit          ack;
    } xfer_t;

    logic [31:0] fmem [4];
    xfer_t       xlog [$];
    bit          rty0_mode, rnd_rty, seen, do_rty;
    int          wait_cnt, consec, stab_err;
    logic [23:0] a0;
    logic        we0;
    logic [31:0] d0;

    initial begin
        fl_ack = 1'b0; fl_rty = 1'b0; fl_dat_i = '0;
        seen = 1'b0; wait_cnt = 0; consec = 0; stab_err = 0;
        forever begin
            @(posedge clk);
            #1;
            fl_ack = 1'b0;
            fl_rty = 1'b0;
            if (!fl_stb) begin
                seen = 1'b0;
            end else begin
                if (!seen) begin
                    seen = 1'b1; a0 = fl_adr; we0 = fl_we; d0 = fl_dat_o;
                    wait_cnt = $urandom_range(0, 2);
                end else if (fl_adr !== a0 || fl_we !== we0 || fl_dat_o !== d0) begin
                    stab_err++;
                end
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    do_rty = (rty0_mode && !fl_we && fl_adr == 24'd0) ||
                             (rnd_rty && consec < 2 && $urandom_range(0, 3) == 0);
                    if (do_rty) begin
                        fl_rty = 1'b1;
                        consec++;
                    end else begin
                        fl_ack = 1'b1;
                        consec = 0;
                        if (fl_we) fmem[fl_adr[3:2]] = fl_dat_o;
                        else       fl_dat_i = fmem[fl_adr[3:2]];
                    end
                    xlog.push_back('{fl_adr, fl_we, fl_dat_o, !do_rty});
                end
            end
        end
    end

    int trig_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (tx_trigger) trig_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // ---------------- reference model of slot contents ----------------
    bit          mvalid [4];
    logic [31:0] mword [4];

    function automatic logic [31:0] exp_tx(input int s);
        if (mvalid[s]) return {mword[s][31:8], 8'(int'(mword[s][1:0]) * 10)};
        return {8'hB0, 8'(46 + s), 8'd127, 8'd30};
    endfunction

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic press(input logic [3:0] m);
        btn_press = m;
        tick();
        btn_press = '0;
    endtask

    task automatic wait_loaded(input int budget);
        for (int i = 0; i < budget && !loaded; i++) tick();
        check("wait_loaded", loaded, 1'b1);
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [7:0] st, d1, d2, bits;
    } vec_t;
    vec_t vt [7];

    int          n, wr_idx, base, outstanding, last_slot, armed, arm_slot, sel;
    bit          exp_trig, exp_ok, any_wr, learn_v, busy_v, rxv;
    logic [3:0]  mask;
    logic [31:0] word, exp;
    logic [23:0] wadr [$];
    logic [31:0] wdat [$];

    initial begin
        vt[0] = '{4'b0010, 8'hC0, 8'h42, 8'h00, 8'd20};
        vt[1] = '{4'b0100, 8'hB0, 8'd48, 8'd127, 8'd30};
        vt[2] = '{4'b0001, 8'hB0, 8'd46, 8'd127, 8'd30};
        vt[3] = '{4'b1000, 8'hB0, 8'd49, 8'd127, 8'd30};
        vt[4] = '{4'b0110, 8'hC0, 8'h42, 8'h00, 8'd20};
        vt[5] = '{4'b1100, 8'hB0, 8'd48, 8'd127, 8'd30};
        vt[6] = '{4'b1111, 8'hB0, 8'd46, 8'd127, 8'd30};

        rst = 1'b0; btn_press = '0; learn = 0; rx_valid = 0; save_req = 0; tx_busy = 0;
        rx_status = '0; rx_data1 = '0; rx_data2 = '0; rx_len = '0;
        rty0_mode = 1; rnd_rty = 0;
        fmem[0] = 32'hFFFFFFFF; fmem[1] = 32'hC0420002; fmem[2] = 32'hFFFFFFFF; fmem[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin mvalid[i] = 0; mword[i] = '0; end
        mvalid[1] = 1; mword[1] = 32'hC0420002;

        repeat (3) tick();
        check("rst_stb", fl_stb, 0);
        check("rst_trig", tx_trigger, 0);
        check("rst_loaded", loaded, 0);
        check("rst_dirty", dirty, 0);
        check("rst_learn_ok", learn_ok, 0);
        check("rst_fl_err", fl_err, 0);
        check("rst_tx", {tx_status, tx_data1, tx_data2, tx_bits}, 0);
        check("rst_flash_port", {fl_adr, fl_we}, 0);

        // Initial load with slot 0 always answering retry.
        rst = 1'b1;
        wait_loaded(3000);
        check("load_responses", xlog.size(), 6);
        n = 0;
        for (int i = 0; i < xlog.size(); i++) if (xlog[i].adr == 0) n++;
        check("slot0_strobes", n, 3);
        if (xlog.size() == 6) begin
            for (int i = 0; i < 3; i++) check($sformatf("slot0_try%0d_rty", i), {xlog[i].ack, xlog[i].we}, 0);
            for (int i = 3; i < 6; i++) check($sformatf("load_adr%0d", i), {xlog[i].adr, xlog[i].ack}, {24'(4 * (i - 2)), 1'b1});
        end
        check("fl_err_after_load", fl_err, 1);
        check("dirty_after_load", dirty, 0);
        rty0_mode = 0;

        // Table-driven press vectors, idle transmitter.
        for (int i = 0; i < 7; i++) begin
            press(vt[i].mask);
            check($sformatf("tbl%0d_trig", i), tx_trigger, 1);
            check($sformatf("tbl%0d_msg", i), {tx_status, tx_data1, tx_data2, tx_bits},
                  {vt[i].st, vt[i].d1, vt[i].d2, vt[i].bits});
            tick();
            check($sformatf("tbl%0d_pulse", i), {tx_trigger, tx_status}, {1'b0, vt[i].st});
        end

        // Learn into slot 3.
        learn = 1; tick();
        press(4'b1000);
        check("learn_press_no_tx", tx_trigger, 0);
        rx_valid = 1; rx_status = 8'hB5; rx_data1 = 8'h01; rx_data2 = 8'h02; rx_len = 2'd0;
        tick(); rx_valid = 0;
        check("rxlen0_ignored", {learn_ok, dirty}, 0);
        rx_valid = 1; rx_status = 8'hB1; rx_data1 = 8'd7; rx_data2 = 8'd100; rx_len = 2'd3;
        tick(); rx_valid = 0;
        check("learn_ok_pulse", {learn_ok, dirty}, 2'b11);
        tick();
        check("learn_ok_one_cycle", learn_ok, 0);
        rx_valid = 1; rx_status = 8'hC3; rx_len = 2'd2;
        tick(); rx_valid = 0;
        check("disarmed_after_learn", learn_ok, 0);
        press(4'b0100);
        learn = 0; tick();
        learn = 1; tick();
        rx_valid = 1; rx_status = 8'hC3; rx_data1 = 8'h11; rx_len = 2'd2;
        tick(); rx_valid = 0;
        check("learn_fall_disarms", learn_ok, 0);
        learn = 0; tick();
        mvalid[3] = 1; mword[3] = 32'hB1076403;
        press(4'b1000);
        check("learned_tx", {tx_trigger, tx_status, tx_data1, tx_data2, tx_bits}, {1'b1, exp_tx(3)});
        press(4'b0100);
        check("slot2_untouched", {tx_trigger, tx_status, tx_data1, tx_data2, tx_bits}, {1'b1, exp_tx(2)});

        // Busy transmitter: newest press replaces pending, one trigger on release.
        tick();
        base = trig_cnt;
        tx_busy = 1;
        press(4'b0001);
        press(4'b0100);
        repeat (3) tick();
        check("busy_no_trigger", trig_cnt - base, 0);
        tx_busy = 0;
        tick();
        check("busy_release_tx", {tx_trigger, tx_status, tx_data1, tx_data2, tx_bits}, {1'b1, exp_tx(2)});
        repeat (4) tick();
        check("busy_single_trigger", trig_cnt - base, 1);

        // Save with random retries; second save request mid-save must be ignored.
        xlog.delete();
        rnd_rty = 1;
        save_req = 1; tick(); save_req = 0;
        check("save_clears_dirty", dirty, 0);
        repeat (3) tick();
        save_req = 1; tick(); save_req = 0;
        n = 0;
        for (int i = 0; i < 800 && n < 4; i++) begin
            tick();
            n = 0;
            foreach (xlog[k]) if (xlog[k].ack && xlog[k].we) n++;
        end
        repeat (40) tick();
        wadr.delete(); wdat.delete();
        foreach (xlog[k]) if (xlog[k].ack && xlog[k].we) begin wadr.push_back(xlog[k].adr); wdat.push_back(xlog[k].dat); end
        check("save_write_count", wadr.size(), 4);
        if (wadr.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("save_adr%0d", i), wadr[i], 24'(4 * i));
            check("save_slot1", wdat[1], 32'hC0420002);
            check("save_slot3", wdat[3], 32'hB1076403);
            check("save_slot0_len", wdat[0][7:0], 0);
            check("save_slot2_len", wdat[2][7:0], 0);
        end
        check("save_stable", stab_err, 0);
        check("fl_err_sticky", fl_err, 1);
        check("dirty_after_save", dirty, 0);
        rnd_rty = 0;

        // Random presses, learn captures and busy against the slot model.
        outstanding = 0; last_slot = 0; armed = 0; arm_slot = 0; any_wr = 0; learn_v = 0;
        for (int it = 0; it < 600; it++) begin
            mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            busy_v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) learn_v = !learn_v;
            rxv = learn_v && mask == 0 && $urandom_range(0, 2) == 0;
            btn_press = mask; tx_busy = busy_v; learn = learn_v; rx_valid = rxv;
            rx_status = 8'($urandom); rx_data1 = 8'($urandom); rx_data2 = 8'($urandom);
            rx_len = 2'($urandom_range(0, 3));
            tick();
            sel = lowest(mask);
            if (!learn_v) armed = 0;
            exp_trig = 0;
            if (sel >= 0 && !learn_v) begin outstanding = 1; last_slot = sel; end
            if (outstanding && !busy_v) begin
                exp_trig = 1;
                exp = exp_tx(last_slot);
                outstanding = 0;
            end
            exp_ok = rxv && rx_len != 0 && armed;
            if (exp_ok) begin
                mvalid[arm_slot] = 1;
                mword[arm_slot] = {rx_status, rx_data1, rx_data2, 6'b0, rx_len};
                armed = 0; any_wr = 1;
            end
            if (sel >= 0 && learn_v) begin armed = 1; arm_slot = sel; end
            check("rnd_trig", tx_trigger, exp_trig);
            if (exp_trig) check("rnd_tx", {tx_status, tx_data1, tx_data2, tx_bits}, exp);
            check("rnd_learn_ok", learn_ok, exp_ok);
        end
        btn_press = '0; tx_busy = 0; learn = 0; rx_valid = 0;
        tick();
        check("rnd_drain", tx_trigger, outstanding);
        if (outstanding) check("rnd_drain_tx", {tx_status, tx_data1, tx_data2, tx_bits}, exp_tx(last_slot));
        check("rnd_dirty", dirty, any_wr);

        // Asynchronous reset while a load strobe is outstanding.
        rst = 0; tick(); rst = 1;
        n = 0;
        for (int i = 0; i < 300 && !(fl_stb && fl_adr == 24'd4); i++) begin tick(); n = i; end
        check("midload_reached", {fl_stb, fl_adr}, {1'b1, 24'd4});
        #2 rst = 0;
        #1;
        check("async_stb_drop", fl_stb, 0);
        check("reset_flags", {loaded, fl_err, dirty}, 0);
        xlog.delete();
        #3 rst = 1;
        for (int i = 0; i < 100 && xlog.size() == 0; i++) tick();
        check("restart_responses", xlog.size() > 0, 1);
        if (xlog.size() > 0) check("restart_adr0", {xlog[0].adr, xlog[0].we}, 0);
        wait_loaded(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/midi_preset_engine.md
Name: midi_preset_engine

Overview:
- Parametrised preset engine for the MIDI pedal controller: N foot buttons, each mapped to a stored 1-3 byte MIDI message.
- Loads presets from SPI flash (wishbone-style word port) after reset.
- Learn mode captures incoming MIDI commands into the selected button slot; save_req writes all slots back to flash.
- Sits between the buttons/midi_in front end and midi_out; replaces the fixed 4-button memmap logic.

Parameters:
BUTTONS_CNT, 4, number of button slots (1..16)
CHANNEL, 0, MIDI channel (0..15) for default CC messages
FIRST_CC, 46, CC number for slot 0; slot b uses FIRST_CC+b
CC_VALUE, 127, data2 of default CC message
BASE_ADDR, 24'h000000, flash byte address of slot 0; slot b at BASE_ADDR+4*b
MAX_RTY, 3, flash retries per word before giving up (1..7)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn_press  in  BUTTONS_CNT  one-cycle press pulses, debounced, bit b = slot b
learn  in  1  level; 1 = learn mode
rx_valid  in  1  one-cycle pulse: complete MIDI command received
rx_status/rx_data1/rx_data2  in  8 each  received bytes
rx_len  in  2  received byte count (0 = invalid)
save_req  in  1  one-cycle pulse: write presets to flash
tx_busy  in  1  midi_out transmitting
tx_trigger  out  1  one-cycle pulse: start transmission
tx_status/tx_data1/tx_data2  out  8 each  message bytes
tx_bits  out  8  bits to send = len*10
fl_adr  out  24  flash byte address
fl_dat_o  out  32  write data
fl_we  out  1  1 = write, 0 = read
fl_stb  out  1  request strobe
fl_dat_i  in  32  read data
fl_ack  in  1  transfer done
fl_rty  in  1  transfer failed, retry
loaded  out  1  initial load finished
dirty  out  1  RAM differs from flash
learn_ok  out  1  one-cycle pulse: slot learned (LED)
fl_err  out  1  sticky: a word exhausted its retries

Behaviour:
- Reset: all outputs 0; all slots invalid; pending empty; learn arm cleared; FSM enters LOAD at slot 0.
- Word format: [31:24] status, [23:16] data1, [15:8] data2, [7:0] = {6'b0, len}.
- A read word is valid iff len != 0 and word != 32'hFFFFFFFF. An invalid or failed slot stays invalid.
- Invalid slot sends the default message: {8'hB0|CHANNEL, FIRST_CC+b, CC_VALUE}, tx_bits = 30.
- FSM states:
  - LOAD: fl_we=0, fl_adr = slot address; fl_stb held until ack or rty.
    - ack: store the slot, advance to the next slot.
    - rty: drop fl_stb for 1 cycle, increment the retry count. At MAX_RTY, set fl_err, mark the slot invalid, advance.
    - After the last slot: go to IDLE and set loaded=1 (stays 1 until reset).
  - IDLE: on save_req, go to SAVE slot 0 and clear dirty.
  - SAVE: fl_we=1, fl_dat_o = slot word (invalid slot writes len=0); same ack/rty policy as LOAD. After the last slot, go to IDLE.
- save_req is ignored in LOAD and SAVE.
- Retry count resets for each word.
- fl_adr, fl_dat_o and fl_we stay stable while fl_stb=1.
- Buttons are accepted in every FSM state; the slot RAM read is independent of the flash port.
- Multiple btn_press bits in one cycle: the lowest index wins, the others are dropped.
- learn=0 press: load a 1-deep pending register; a newer press overwrites an untransmitted pending one.
- Transmit rule: when pending is set and tx_busy=0, in the next cycle:
  - tx_trigger=1 for exactly 1 cycle;
  - tx_* are driven from the slot (or its default);
  - pending is cleared.
  - tx_* hold until the next trigger.
- Latency: press at cycle N with tx_busy=0 and no pending → tx_trigger at N+1.
- learn=1 press: arm that slot; no transmission.
- Next rx_valid with rx_len != 0 and learn=1:
  - write {rx_status, rx_data1, rx_data2, rx_len} to the armed slot;
  - mark it valid, set dirty, pulse learn_ok, disarm.
- rx_len=0 is ignored.
- learn falling disarms the slot.
- Learn write and LOAD ack on the same slot in the same cycle: the learn write wins.
- Learn write during SAVE sets dirty again.
- Reset mid-transfer: fl_stb drops asynchronously and the FSM restarts LOAD.

Decomposition:
- Package midi_pkg:
  - midi_msg_t struct {status, data1, data2, len[1:0]};
  - constants CC_MSG=8'hB0 and PC_MSG=8'hC0;
  - fl_state_t enum {LOAD, IDLE, SAVE};
  - functions msg_to_word and word_to_msg.
- Sub-module midi_preset_flash_seq: LOAD/SAVE FSM, retry counter, flash port. It exposes the slot index plus rd_valid/rd_msg/wr_msg handshakes to the top, which owns the slot RAM, pending register and learn logic.

Test Plan:
- Flash model returns slot1 = 32'hC0420002 and slots 0/2/3 = 32'hFFFFFFFF; press slot1 → tx 8'hC0/8'h42/-, tx_bits=20. Press slot2 → 8'hB0/8'd48/8'd127, tx_bits=30.
- fl_rty on every slot0 attempt with MAX_RTY=3 → exactly 3 strobes on address 0, then fl_err=1 and slot0 default; loaded=1 after slot 3.
- learn=1, press slot3, rx {8'hB1, 8'd7, 8'd100, len 3} → learn_ok pulse, dirty=1. learn=0, press slot3 → tx B1/07/64, tx_bits=30.
- tx_busy=1, press slot0 then slot2 → no trigger. Release busy → single trigger with slot2 content.
- save_req after learn → 4 writes at addresses 0,4,8,12, slot3 data 32'hB1076403, dirty=0 at start.
- Assert rst mid-LOAD with fl_stb=1 → fl_stb=0 immediately; load restarts at address 0.
